// File: rtl/regfile_pipe.sv
// Register file for the pipelined processor: two combinational read ports,
// two clocked write ports (E, M) with M priority, optional same-cycle bypass.
module regfile_pipe #(
  parameter int                DATA_W   = 64,
  parameter int                ADDR_W   = 4,
  parameter int                NUM_REGS = 15,
  parameter int                SP_ID    = 4,
  parameter logic [DATA_W-1:0] SP_RESET = '0,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ADDR_W-1:0] dbg_id,
  output logic [DATA_W-1:0] dbg_val,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] RNONE = '1;

  if (NUM_REGS > (2 ** ADDR_W) - 1) begin : gBadNumRegs
    $error("regfile_pipe: NUM_REGS must not exceed 2**ADDR_W-1");
  end
  if (SP_ID >= NUM_REGS) begin : gBadSpId
    $error("regfile_pipe: SP_ID must be below NUM_REGS");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              validE;
  logic              validM;
  logic [1:0]        numWrites;
  logic [16:0]       countSum;
  logic [DATA_W-1:0] storedA;
  logic [DATA_W-1:0] storedB;

  // IDs at or above NUM_REGS are treated exactly like RNONE.
  function automatic logic idValid(input logic [ADDR_W-1:0] id);
    return (id != RNONE) && (32'(id) < NUM_REGS);
  endfunction

  assign validE = wr_en && rst_n && idValid(dstE);
  assign validM = wr_en && rst_n && idValid(dstM);

  always_comb begin
    numWrites = {1'b0, validE} + {1'b0, validM};
    if (validE && validM && (dstE == dstM)) begin
      numWrites = 2'd1;
    end
  end

  assign countSum = {1'b0, wr_count} + {15'b0, numWrites};

  // M is assigned after E so it wins when both target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_ID) ? SP_RESET : '0;
      end
      wr_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (validE && (dstE == ADDR_W'(i))) regs[i] <= valE;
        if (validM && (dstM == ADDR_W'(i))) regs[i] <= valM;
      end
      wr_count <= countSum[16] ? 16'hFFFF : countSum[15:0];
    end
  end

  // Out-of-range and RNONE IDs never match a physical register, so they read 0.
  always_comb begin
    storedA = '0;
    storedB = '0;
    dbg_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (srcA == ADDR_W'(i))   storedA = regs[i];
      if (srcB == ADDR_W'(i))   storedB = regs[i];
      if (dbg_id == ADDR_W'(i)) dbg_val = regs[i];
    end
  end

  always_comb begin
    valA = storedA;
    valB = storedB;
    if (BYPASS) begin
      if (validM && (srcA == dstM))      valA = valM;
      else if (validE && (srcA == dstE)) valA = valE;
      if (validM && (srcB == dstM))      valB = valM;
      else if (validE && (srcB == dstE)) valB = valE;
    end
  end

endmodule

// File: tb/tb_regfile_pipe.sv
// Directed bench for regfile_pipe: bypassed, non-bypassed and reduced-size
// instances share one stimulus stream; expectations flow through exp_q.
module tb_regfile_pipe;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam logic [AW-1:0] RN = 4'hF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] dstE = RN, dstM = RN, srcA = RN, srcB = RN, dbg_id = '0;
  logic [DW-1:0] valE = '0, valM = '0;

  logic [DW-1:0] valAa, valBa, dbgA, valAb, valBb, dbgB, valAc, valBc, dbgC;
  logic [15:0]   cntA, cntB, cntC;

  regfile_pipe #(.SP_RESET(64'h100), .BYPASS(1'b1)) uA (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valAa),
    .valB(valBa), .dbg_id(dbg_id), .dbg_val(dbgA), .wr_count(cntA));

  regfile_pipe #(.SP_RESET(64'h100), .BYPASS(1'b0)) uB (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valAb),
    .valB(valBb), .dbg_id(dbg_id), .dbg_val(dbgB), .wr_count(cntB));

  regfile_pipe #(.NUM_REGS(8), .SP_RESET(64'h100), .BYPASS(1'b1)) uC (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .srcA(srcA), .srcB(srcB), .valA(valAc),
    .valB(valBc), .dbg_id(dbg_id), .dbg_val(dbgC), .wr_count(cntC));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q[$];

  task automatic pushExp(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    wr_en = 1'b0;
    dstE  = RN;
    dstM  = RN;
  endtask

  task automatic writeEdge(input logic we, input logic [AW-1:0] de, input logic [DW-1:0] ve,
                           input logic [AW-1:0] dm, input logic [DW-1:0] vm);
    wr_en = we; dstE = de; valE = ve; dstM = dm; valM = vm;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, sampled while rst_n is held low
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      dbg_id = AW'(i);
      pushExp((i == 4) ? 64'h100 : 64'h0);
      #0.5;
      chk("reset_dbg", dbgA);
    end
    srcA = 4; srcB = 0;
    pushExp(64'h100); pushExp(64'h0); pushExp(64'h0);
    #0.5;
    chk("reset_valA_sp", valAa);
    chk("reset_valB_r0", valBa);
    chk("reset_wr_count", 64'(cntA));
    @(negedge clk) rst_n = 1'b1;

    // Mid-cycle reset: clears immediately and discards the write on the next edge
    @(posedge clk); #1;
    writeEdge(1'b1, 2, 64'h99, RN, 64'h0);
    wr_en = 1'b1; dstE = 1; valE = 64'h420;
    @(negedge clk);
    rst_n = 1'b0;
    dbg_id = 2;
    pushExp(64'h0); pushExp(64'h0);
    #1;
    chk("midreset_async_r2", dbgA);
    chk("midreset_async_count", 64'(cntA));
    @(posedge clk); #1;
    idle();
    dbg_id = 1;
    pushExp(64'h0); pushExp(64'h0);
    #1;
    chk("midreset_r1_discarded", dbgA);
    chk("midreset_wr_count", 64'(cntA));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single writes
    writeEdge(1'b1, 1, 64'h420, RN, 64'h0);
    srcA = 1;
    pushExp(64'h420); pushExp(64'd1);
    #1;
    chk("single_valA_r1", valAa);
    chk("single_count1", 64'(cntA));
    @(posedge clk); #1;
    writeEdge(1'b1, 4, 64'h20, RN, 64'h0);
    srcB = 4;
    pushExp(64'h20); pushExp(64'd2);
    #1;
    chk("single_valB_r4", valBa);
    chk("single_count2", 64'(cntA));

    // Dual write, then collision with M priority
    @(posedge clk); #1;
    writeEdge(1'b1, 7, 64'h11, 6, 64'h22);
    dbg_id = 7; pushExp(64'h11); #1; chk("dual_r7", dbgA);
    dbg_id = 6; pushExp(64'h22); #1; chk("dual_r6", dbgA);
    pushExp(64'd4); #1; chk("dual_count", 64'(cntA));
    @(posedge clk); #1;
    writeEdge(1'b1, 3, 64'hAA, 3, 64'hBB);
    dbg_id = 3; pushExp(64'hBB); #1; chk("collide_r3", dbgA);
    pushExp(64'd5); #1; chk("collide_count", 64'(cntA));

    // Bypass versus stored-only reads
    @(posedge clk); #1;
    wr_en = 1'b1; dstE = 1; valE = 64'h500; srcA = 1; dbg_id = 1;
    pushExp(64'h500); pushExp(64'h420); pushExp(64'h420);
    #1;
    chk("bypass_valA_fwd", valAa);
    chk("bypass_dbg_stored", dbgA);
    chk("nobypass_valA_old", valAb);
    @(posedge clk); #1;
    idle();
    pushExp(64'h500); pushExp(64'h500); pushExp(64'd6);
    #1;
    chk("bypass_valA_after", valAa);
    chk("nobypass_valA_after", valAb);
    chk("bypass_count", 64'(cntA));

    // M beats E on forwarding; srcA == srcB
    @(posedge clk); #1;
    wr_en = 1'b1; dstE = 2; valE = 64'h77; dstM = 2; valM = 64'h88; srcA = 2; srcB = 2;
    pushExp(64'h88); pushExp(64'h88); pushExp(64'h0);
    #1;
    chk("fwd_m_priority_A", valAa);
    chk("fwd_m_priority_B", valBa);
    chk("nobypass_r2_stored", valAb);

    // Stall: wr_en low suppresses both writes and forwarding
    wr_en = 1'b0; dstM = RN; valE = 64'h99;
    pushExp(64'h0);
    #1;
    chk("stall_no_forward", valAa);
    repeat (3) @(posedge clk);
    #1;
    idle();
    dbg_id = 2;
    pushExp(64'h0); pushExp(64'd6);
    #1;
    chk("stall_r2_held", dbgA);
    chk("stall_count", 64'(cntA));

    // RNONE reads and a bubble write
    srcA = RN;
    pushExp(64'h0); #1; chk("rnone_read", valAa);
    @(posedge clk); #1;
    writeEdge(1'b1, RN, 64'h123, RN, 64'h456);
    srcA = 1;
    pushExp(64'h500); pushExp(64'd6);
    #1;
    chk("bubble_r1_held", valAa);
    chk("bubble_count", 64'(cntA));

    // ID 9 is out of range for the 8-register instance only
    @(posedge clk); #1;
    writeEdge(1'b1, 9, 64'h55, RN, 64'h0);
    srcA = 9;
    pushExp(64'h0); pushExp(64'h55); pushExp(64'd6); pushExp(64'd7);
    #1;
    chk("small_id9_read", valAc);
    chk("big_id9_read", valAa);
    chk("small_id9_count", 64'(cntC));
    chk("big_id9_count", 64'(cntA));

    // Saturation: two distinct writes per edge
    @(posedge clk); #1;
    wr_en = 1'b1; dstE = 0; valE = 64'hA; dstM = 5; valM = 64'hB;
    repeat (32768) @(posedge clk);
    #1;
    idle();
    pushExp(64'hFFFF); pushExp(64'hFFFF); pushExp(64'hFFFF);
    #1;
    chk("sat_count_A", 64'(cntA));
    chk("sat_count_B", 64'(cntB));
    chk("sat_count_C", 64'(cntC));
    @(posedge clk); #1;
    writeEdge(1'b1, 0, 64'hC, RN, 64'h0);
    dbg_id = 0;
    pushExp(64'hFFFF); pushExp(64'hC);
    #1;
    chk("sat_held", 64'(cntA));
    chk("sat_write_r0", dbgA);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: %0d queued, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
